// File: rtl/ospfb_run_ctrl.sv
// ospfb_run_ctrl: run-sequencing controller for the OSPFB datapath.
// Sends the FFT config word, gates the OSPFB enable, counts FFT events and
// halts on framing faults. Optional build macro OSPFB_RUN_CTRL_OVF_HALT_EN
// makes an FFT overflow in RUN/DRAIN a halting fault (err_code 3).
module ospfb_run_ctrl #(
  parameter int CONF_WID    = 8,
  parameter int FWD_INV     = 1,
  parameter int SCALE_SCHED = 0,
  parameter int ARM_TIMEOUT = 1024,
  parameter int FRAME_LIMIT = 0,
  parameter int CNT_WID     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                event_frame_started,
  input  logic                event_tlast_unexpected,
  input  logic                event_tlast_missing,
  input  logic                event_fft_overflow,
  input  logic                event_data_in_channel_halt,
  output logic [CONF_WID-1:0] m_axis_config_tdata,
  output logic                m_axis_config_tvalid,
  input  logic                m_axis_config_tready,
  output logic                en,
  output logic                busy,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [2:0]          state,
  output logic [31:0]         frame_count,
  output logic [CNT_WID-1:0]  ovf_count,
  output logic [CNT_WID-1:0]  halt_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_ARM    = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_HALT   = 3'd5
  } run_state_t;

  localparam int TMR_WID = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CONF_WID-1:0] CONF_WORD =
    CONF_WID'((SCALE_SCHED << 1) | (FWD_INV & 1));
  localparam logic [CNT_WID-1:0] CNT_MAX = {CNT_WID{1'b1}};

  run_state_t         cur_st, nxt_st;
  logic [TMR_WID-1:0] tmr, tmr_n;
  logic [1:0]         err_n;
  logic               cnt_clr, frame_inc, ovf_inc, stv_inc;
  logic               tlast_fault, ovf_fault, limit_hit;
  logic [31:0]        frame_nxt;

  // The config word is fixed at elaboration, so the channel data never moves.
  assign m_axis_config_tdata = CONF_WORD;
  assign state               = cur_st;

  assign tlast_fault = event_tlast_unexpected | event_tlast_missing;
`ifdef OSPFB_RUN_CTRL_OVF_HALT_EN
  assign ovf_fault = event_fft_overflow;
`else
  assign ovf_fault = 1'b0;
`endif

  // Frame count including this cycle's event, used for the auto-stop test.
  assign frame_nxt = frame_count + 32'(frame_inc);
  assign limit_hit = (FRAME_LIMIT != 0) && (frame_nxt >= 32'(FRAME_LIMIT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_st <= S_IDLE;
    else     cur_st <= nxt_st;
  end

  // Next-state, error code, arm timer and counter enables; faults beat stop/limit.
  always_comb begin
    nxt_st    = cur_st;
    err_n     = err_code;
    tmr_n     = tmr;
    cnt_clr   = 1'b0;
    frame_inc = 1'b0;
    ovf_inc   = 1'b0;
    stv_inc   = 1'b0;
    case (cur_st)
      S_IDLE: begin
        if (start) begin
          nxt_st  = S_CONFIG;
          cnt_clr = 1'b1;
        end
      end
      S_CONFIG: begin
        if (m_axis_config_tvalid && m_axis_config_tready) begin
          nxt_st = S_ARM;
          tmr_n  = TMR_WID'(ARM_TIMEOUT);
        end
      end
      S_ARM: begin
        frame_inc = event_frame_started;
        ovf_inc   = event_fft_overflow;
        stv_inc   = event_data_in_channel_halt;
        tmr_n     = tmr - 1'b1;
        if (event_frame_started) begin
          nxt_st = stop ? S_IDLE : S_RUN;
        end else if (tmr == TMR_WID'(1)) begin
          nxt_st = S_HALT;
          err_n  = 2'd1;
        end else if (stop) begin
          nxt_st = S_IDLE;
        end
      end
      S_RUN, S_DRAIN: begin
        frame_inc = event_frame_started;
        ovf_inc   = event_fft_overflow;
        stv_inc   = event_data_in_channel_halt;
        if (tlast_fault) begin
          nxt_st = S_HALT;
          err_n  = 2'd2;
        end else if (ovf_fault) begin
          nxt_st = S_HALT;
          err_n  = 2'd3;
        end else if (cur_st == S_RUN) begin
          if (stop || limit_hit) nxt_st = S_DRAIN;
        end else if (event_frame_started) begin
          nxt_st = S_IDLE;
        end
      end
      S_HALT: begin
        if (clear) begin
          nxt_st = S_IDLE;
          err_n  = 2'd0;
        end
      end
      default: nxt_st = S_IDLE;
    endcase
  end

  // Registered outputs, arm timer and saturating/wrapping event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en                   <= 1'b0;
      busy                 <= 1'b0;
      error                <= 1'b0;
      err_code             <= 2'd0;
      m_axis_config_tvalid <= 1'b0;
      tmr                  <= '0;
      frame_count          <= '0;
      ovf_count            <= '0;
      halt_count           <= '0;
    end else begin
      en                   <= (nxt_st == S_ARM) || (nxt_st == S_RUN) || (nxt_st == S_DRAIN);
      busy                 <= (nxt_st != S_IDLE) && (nxt_st != S_HALT);
      error                <= (nxt_st == S_HALT);
      err_code             <= err_n;
      m_axis_config_tvalid <= (nxt_st == S_CONFIG);
      tmr                  <= tmr_n;
      if (cnt_clr) begin
        frame_count <= '0;
        ovf_count   <= '0;
        halt_count  <= '0;
      end else begin
        if (frame_inc) frame_count <= frame_nxt;
        if (ovf_inc && (ovf_count != CNT_MAX)) ovf_count <= ovf_count + 1'b1;
        if (stv_inc && (halt_count != CNT_MAX)) halt_count <= halt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ospfb_run_ctrl.sv
// tb_ospfb_run_ctrl: self-checking bench for ospfb_run_ctrl (vector table,
// directed corner sequences and a randomized run against a behavioural model).
module tb_ospfb_run_ctrl;

  localparam int CONF_WID    = 8;
  localparam int ARM_TIMEOUT = 16;
  localparam int FRAME_LIMIT = 4;
  localparam int CNT_WID     = 4;
  localparam int CNT_MAX     = (1 << CNT_WID) - 1;
`ifdef OSPFB_RUN_CTRL_OVF_HALT_EN
  localparam bit OVF_HALT = 1'b1;
`else
  localparam bit OVF_HALT = 1'b0;
`endif

  logic                clk, rst;
  logic                start, stop, clear, tready;
  logic                ev_fs, ev_tlu, ev_tlm, ev_ovf, ev_stv;
  logic [CONF_WID-1:0] tdata;
  logic                tvalid, en, busy, error;
  logic [1:0]          err_code;
  logic [2:0]          state;
  logic [31:0]         frame_count;
  logic [CNT_WID-1:0]  ovf_count, halt_count;

  int n_checks = 0;
  int n_errors = 0;

  ospfb_run_ctrl #(
    .CONF_WID(CONF_WID), .FWD_INV(1), .SCALE_SCHED(0),
    .ARM_TIMEOUT(ARM_TIMEOUT), .FRAME_LIMIT(FRAME_LIMIT), .CNT_WID(CNT_WID)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .event_frame_started(ev_fs), .event_tlast_unexpected(ev_tlu),
    .event_tlast_missing(ev_tlm), .event_fft_overflow(ev_ovf),
    .event_data_in_channel_halt(ev_stv),
    .m_axis_config_tdata(tdata), .m_axis_config_tvalid(tvalid),
    .m_axis_config_tready(tready),
    .en(en), .busy(busy), .error(error), .err_code(err_code), .state(state),
    .frame_count(frame_count), .ovf_count(ovf_count), .halt_count(halt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural reference: mode number, cycles spent armed, plain counters.
  int          m_state;
  int          m_armed;
  logic [31:0] m_frames;
  int          m_ovf, m_stv, m_err;

  function void model_reset();
    m_state = 0; m_armed = 0; m_frames = 0; m_ovf = 0; m_stv = 0; m_err = 0;
  endfunction

  function void model_count();
    if (ev_fs) m_frames = m_frames + 32'd1;
    if (ev_ovf) m_ovf = (m_ovf + 1 > CNT_MAX) ? CNT_MAX : m_ovf + 1;
    if (ev_stv) m_stv = (m_stv + 1 > CNT_MAX) ? CNT_MAX : m_stv + 1;
  endfunction

  function void model_step();
    case (m_state)
      0: if (start) begin
        m_state = 1; m_frames = 0; m_ovf = 0; m_stv = 0;
      end
      1: if (tready) begin
        m_state = 2; m_armed = 0;
      end
      2: begin
        model_count();
        m_armed = m_armed + 1;
        if (ev_fs) m_state = stop ? 0 : 3;
        else if (m_armed >= ARM_TIMEOUT) begin m_state = 5; m_err = 1; end
        else if (stop) m_state = 0;
      end
      3, 4: begin
        model_count();
        if (ev_tlu || ev_tlm) begin m_state = 5; m_err = 2; end
        else if (OVF_HALT && ev_ovf) begin m_state = 5; m_err = 3; end
        else if (m_state == 3) begin
          if (stop || (m_frames >= 32'(FRAME_LIMIT))) m_state = 4;
        end else if (ev_fs) m_state = 0;
      end
      5: if (clear) begin m_state = 0; m_err = 0; end
      default: m_state = 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic apply_stimulus(input logic a_start, input logic a_stop, input logic a_clear,
                                input logic a_tready, input logic a_fs, input logic a_tlu,
                                input logic a_tlm, input logic a_ovf, input logic a_stv);
    start = a_start; stop = a_stop; clear = a_clear; tready = a_tready;
    ev_fs = a_fs; ev_tlu = a_tlu; ev_tlm = a_tlm; ev_ovf = a_ovf; ev_stv = a_stv;
  endtask

  task automatic idle_inputs();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_model(input int cyc);
    check_output($sformatf("rnd%0d_state", cyc), 32'(state), 32'(m_state));
    check_output($sformatf("rnd%0d_en", cyc), 32'(en), 32'(m_state >= 2 && m_state <= 4));
    check_output($sformatf("rnd%0d_busy", cyc), 32'(busy), 32'(m_state >= 1 && m_state <= 4));
    check_output($sformatf("rnd%0d_error", cyc), 32'(error), 32'(m_state == 5));
    check_output($sformatf("rnd%0d_tvalid", cyc), 32'(tvalid), 32'(m_state == 1));
    check_output($sformatf("rnd%0d_err_code", cyc), 32'(err_code), 32'(m_err));
    check_output($sformatf("rnd%0d_frames", cyc), frame_count, m_frames);
    check_output($sformatf("rnd%0d_ovf", cyc), 32'(ovf_count), 32'(m_ovf));
    check_output($sformatf("rnd%0d_halt", cyc), 32'(halt_count), 32'(m_stv));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Brings the controller from IDLE through the handshake into RUN.
  task automatic go_run();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    idle_inputs();
  endtask

  typedef struct {
    logic        start, stop, clear, tready, fs, tlm;
    logic [2:0]  st;
    logic        en, tvalid, busy, error;
    logic [1:0]  ec;
    logic [31:0] fc;
  } vec_t;

  vec_t vecs[14];

  // Safety net against a stuck run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n_valid;
    int n_wait;

    vecs[0]  = '{1,0,0,0,0,0, 3'd1, 0,1,1,0, 2'd0, 32'd0};
    vecs[1]  = '{0,0,0,0,0,0, 3'd1, 0,1,1,0, 2'd0, 32'd0};
    vecs[2]  = '{0,1,0,0,0,0, 3'd1, 0,1,1,0, 2'd0, 32'd0};
    vecs[3]  = '{0,0,0,1,0,0, 3'd2, 1,0,1,0, 2'd0, 32'd0};
    vecs[4]  = '{0,0,0,0,1,0, 3'd3, 1,0,1,0, 2'd0, 32'd1};
    vecs[5]  = '{0,0,0,0,1,1, 3'd5, 0,0,0,1, 2'd2, 32'd2};
    vecs[6]  = '{0,0,0,0,0,0, 3'd5, 0,0,0,1, 2'd2, 32'd2};
    vecs[7]  = '{1,0,0,0,1,0, 3'd5, 0,0,0,1, 2'd2, 32'd2};
    vecs[8]  = '{0,0,1,0,0,0, 3'd0, 0,0,0,0, 2'd0, 32'd2};
    vecs[9]  = '{0,1,0,0,0,0, 3'd0, 0,0,0,0, 2'd0, 32'd2};
    vecs[10] = '{1,0,0,0,0,0, 3'd1, 0,1,1,0, 2'd0, 32'd0};
    vecs[11] = '{0,0,0,1,0,0, 3'd2, 1,0,1,0, 2'd0, 32'd0};
    vecs[12] = '{0,1,0,0,0,0, 3'd0, 0,0,0,0, 2'd0, 32'd0};
    vecs[13] = '{0,0,1,0,0,0, 3'd0, 0,0,0,0, 2'd0, 32'd0};

    rst = 1'b1;
    idle_inputs();
    model_reset();
    #3;
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_en", 32'(en), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_err_code", 32'(err_code), 32'd0);
    check_output("rst_tvalid", 32'(tvalid), 32'd0);
    check_output("rst_tdata", 32'(tdata), 32'h01);
    check_output("rst_frames", frame_count, 32'd0);
    check_output("rst_ovf", 32'(ovf_count), 32'd0);
    check_output("rst_halt", 32'(halt_count), 32'd0);
    do_reset();

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].start, vecs[i].stop, vecs[i].clear, vecs[i].tready,
                     vecs[i].fs, 0, vecs[i].tlm, 0, 0);
      tick();
      check_output($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check_output($sformatf("vec%0d_en", i), 32'(en), 32'(vecs[i].en));
      check_output($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(vecs[i].tvalid));
      check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check_output($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].error));
      check_output($sformatf("vec%0d_err_code", i), 32'(err_code), 32'(vecs[i].ec));
      check_output($sformatf("vec%0d_frames", i), frame_count, vecs[i].fc);
    end
    idle_inputs();

    $display("[TB] config handshake with tready held off");
    do_reset();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (tvalid === 1'b1) n_valid++;
      check_output($sformatf("cfg%0d_tdata", i), 32'(tdata), 32'h01);
      check_output($sformatf("cfg%0d_en_low", i), 32'(en), 32'd0);
      tready = (i == 5);
      tick();
    end
    tready = 1'b0;
    check_output("cfg_tvalid_cycles", 32'(n_valid), 32'd6);
    check_output("cfg_tvalid_dropped", 32'(tvalid), 32'd0);
    check_output("cfg_en_after_hs", 32'(en), 32'd1);
    check_output("cfg_state_arm", 32'(state), 32'd2);

    $display("[TB] arm timeout");
    n_wait = 0;
    while (state !== 3'd5 && n_wait < 100) begin
      tick();
      n_wait++;
    end
    check_output("arm_timeout_cycles", 32'(n_wait), 32'(ARM_TIMEOUT));
    check_output("arm_timeout_err_code", 32'(err_code), 32'd1);
    check_output("arm_timeout_en", 32'(en), 32'd0);
    check_output("arm_timeout_error", 32'(error), 32'd1);
    apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    check_output("clear_state", 32'(state), 32'd0);
    check_output("clear_error", 32'(error), 32'd0);
    check_output("clear_err_code", 32'(err_code), 32'd0);

    $display("[TB] frame limit auto-stop");
    do_reset();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0); tick();
    idle_inputs();
    for (int f = 1; f <= 5; f++) begin
      repeat ((f == 1) ? 3 : 63) tick();
      if (f == 5) begin
        check_output("drain_state", 32'(state), 32'd4);
        check_output("drain_en_held", 32'(en), 32'd1);
      end
      ev_fs = 1'b1;
      tick();
      ev_fs = 1'b0;
      if (f == 1) check_output("limit_run_entry", 32'(state), 32'd3);
      if (f == 4) begin
        check_output("limit_drain_entry", 32'(state), 32'd4);
        check_output("limit_drain_frames", frame_count, 32'd4);
      end
    end
    check_output("limit_idle_state", 32'(state), 32'd0);
    check_output("limit_idle_frames", frame_count, 32'd5);
    check_output("limit_en_fall", 32'(en), 32'd0);
    check_output("limit_busy_fall", 32'(busy), 32'd0);

    $display("[TB] overflow burst in RUN");
    do_reset();
    go_run();
    check_output("ovf_pre_state", 32'(state), 32'd3);
    ev_ovf = 1'b1;
    tick();
`ifdef OSPFB_RUN_CTRL_OVF_HALT_EN
    check_output("ovf_first_state", 32'(state), 32'd5);
    check_output("ovf_first_err_code", 32'(err_code), 32'd3);
    check_output("ovf_first_count", 32'(ovf_count), 32'd1);
`else
    check_output("ovf_first_state", 32'(state), 32'd3);
    check_output("ovf_first_count", 32'(ovf_count), 32'd1);
`endif
    repeat (19) tick();
    ev_ovf = 1'b0;
`ifdef OSPFB_RUN_CTRL_OVF_HALT_EN
    check_output("ovf_final_count", 32'(ovf_count), 32'd1);
    check_output("ovf_final_state", 32'(state), 32'd5);
`else
    check_output("ovf_final_count", 32'(ovf_count), 32'(CNT_MAX));
    check_output("ovf_final_err_code", 32'(err_code), 32'd0);
`endif

    $display("[TB] reset mid-RUN");
    do_reset();
    go_run();
    ev_stv = 1'b1;
    tick();
    ev_stv = 1'b0;
    check_output("midrst_pre_frames", frame_count, 32'd1);
    rst = 1'b1;
    #2;
    check_output("midrst_en", 32'(en), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_state", 32'(state), 32'd0);
    check_output("midrst_frames", frame_count, 32'd0);
    check_output("midrst_halt", 32'(halt_count), 32'd0);
    do_reset();

    $display("[TB] randomized run against model");
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 63) == 0,
                     $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 7) == 0);
      tick();
      check_model(c);
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
